// File: rtl/seq_shift_ctrl_if.sv
// Request, shifter and result signals of the shift sequencer.
// The slave side is the sequencer; the master side is its environment.
interface seq_shift_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int AMT_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [AMT_W-1:0]  in_shamt;
    logic              in_dir;

    logic [DATA_W-1:0] sh_data;
    logic [2:0]        sh_shamt;
    logic              sh_dir;
    logic [DATA_W-1:0] sh_result;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              busy;

    modport slave (
        input  in_valid, in_data, in_shamt, in_dir, sh_result, out_ready,
        output in_ready, sh_data, sh_shamt, sh_dir, out_valid, out_data, busy
    );

    modport master (
        output in_valid, in_data, in_shamt, in_dir, sh_result, out_ready,
        input  in_ready, sh_data, sh_shamt, sh_dir, out_valid, out_data, busy
    );
endinterface

// File: rtl/seq_shift_ctrl.sv
// Sequencer in front of an 8-bit, 3-bit-shamt combinational barrel shifter.
// A request of up to 15 bits is broken into passes of at most MAX_STEP bits;
// each pass result is captured back into the accumulator, which is also the
// value presented to the shifter and on the result port.
module seq_shift_ctrl #(
    parameter int DATA_W   = 8,
    parameter int AMT_W    = 4,
    parameter int MAX_STEP = 7
) (
    input  logic            clk,
    input  logic            rst,
    seq_shift_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] acc;
    logic [AMT_W-1:0]  rem;
    logic              dir_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic              busy_r;

    logic [2:0]        step;
    logic [AMT_W-1:0]  rem_next;

    // Per-pass amount: full steps while more than MAX_STEP remains, then the tail.
    always_comb begin
        step = 3'd0;
        if (state == SHIFT) begin
            step = (rem > AMT_W'(MAX_STEP)) ? 3'(MAX_STEP) : rem[2:0];
        end
        rem_next = rem - AMT_W'(step);
    end

    assign bus.sh_data   = acc;
    assign bus.sh_shamt  = step;
    assign bus.sh_dir    = dir_r;
    assign bus.out_data  = acc;
    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;

    // Control FSM with accumulator; handshake flags are registered next to the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            rem         <= '0;
            dir_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        acc        <= bus.in_data;
                        rem        <= bus.in_shamt;
                        dir_r      <= bus.in_dir;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        if (bus.in_shamt == '0) begin
                            state       <= DONE;
                            out_valid_r <= 1'b1;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    acc <= bus.sh_result;
                    rem <= rem_next;
                    if (rem_next == '0) begin
                        state       <= DONE;
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    // Requests arriving here are ignored; only IDLE accepts.
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_shift_ctrl.sv
// Directed bench for seq_shift_ctrl with a behavioural 8-bit barrel shifter.
module tb_seq_shift_ctrl;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    seq_shift_ctrl_if #(.DATA_W(8), .AMT_W(4)) bus ();

    seq_shift_ctrl #(.DATA_W(8), .AMT_W(4), .MAX_STEP(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // External combinational shifter, logical with zero fill.
    assign bus.sh_result = bus.sh_dir ? (bus.sh_data << bus.sh_shamt)
                                      : (bus.sh_data >> bus.sh_shamt);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic [3:0] amt, input logic dir);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_shamt = amt;
        bus.in_dir   = dir;
        tick();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_shamt = 4'd0;
        bus.in_dir   = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_in_ready",  bus.in_ready,  1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data",  bus.out_data,  0);
        check("rst_busy",      bus.busy,      0);
        check("rst_sh_shamt",  bus.sh_shamt,  0);
        check("rst_sh_dir",    bus.sh_dir,    0);
        check("rst_sh_data",   bus.sh_data,   0);

        // 1: 0xB5 << 3
        send(8'hB5, 4'd3, 1'b1);
        check("t1_c1_busy",     bus.busy,      1);
        check("t1_c1_in_ready", bus.in_ready,  0);
        check("t1_c1_shamt",    bus.sh_shamt,  3);
        check("t1_c1_dir",      bus.sh_dir,    1);
        check("t1_c1_shdata",   bus.sh_data,   8'hB5);
        check("t1_c1_valid",    bus.out_valid, 0);
        tick();
        check("t1_c2_valid",    bus.out_valid, 1);
        check("t1_c2_data",     bus.out_data,  8'hA8);
        check("t1_c2_shamt",    bus.sh_shamt,  0);
        tick();
        check("t1_c3_in_ready", bus.in_ready,  1);
        check("t1_c3_busy",     bus.busy,      0);
        check("t1_c3_valid",    bus.out_valid, 0);

        // 2: 0xB5 >> 3
        send(8'hB5, 4'd3, 1'b0);
        check("t2_c1_valid", bus.out_valid, 0);
        tick();
        check("t2_c2_valid", bus.out_valid, 1);
        check("t2_c2_data",  bus.out_data,  8'h16);
        tick();

        // 3a: 0xFF >> 8 in passes 7,1
        send(8'hFF, 4'd8, 1'b0);
        check("t3a_c1_shamt", bus.sh_shamt, 7);
        check("t3a_c1_shdat", bus.sh_data,  8'hFF);
        tick();
        check("t3a_c2_shamt", bus.sh_shamt, 1);
        check("t3a_c2_shdat", bus.sh_data,  8'h01);
        check("t3a_c2_valid", bus.out_valid, 0);
        tick();
        check("t3a_c3_valid", bus.out_valid, 1);
        check("t3a_c3_data",  bus.out_data,  8'h00);
        tick();

        // 3b: 0xFF >> 15 in passes 7,7,1
        send(8'hFF, 4'd15, 1'b0);
        check("t3b_c1_shamt", bus.sh_shamt, 7);
        tick();
        check("t3b_c2_shamt", bus.sh_shamt, 7);
        check("t3b_c2_shdat", bus.sh_data,  8'h01);
        tick();
        check("t3b_c3_shamt", bus.sh_shamt, 1);
        check("t3b_c3_valid", bus.out_valid, 0);
        tick();
        check("t3b_c4_valid", bus.out_valid, 1);
        check("t3b_c4_data",  bus.out_data,  8'h00);
        tick();

        // 4: zero amount goes straight to DONE
        check("t4_c0_shamt", bus.sh_shamt, 0);
        send(8'h3C, 4'd0, 1'b1);
        check("t4_c1_valid", bus.out_valid, 1);
        check("t4_c1_data",  bus.out_data,  8'h3C);
        check("t4_c1_shamt", bus.sh_shamt,  0);
        check("t4_c1_busy",  bus.busy,      1);
        tick();
        check("t4_c2_idle",  bus.in_ready,  1);

        // 5: backpressure with a competing request held in DONE
        bus.out_ready = 1'b0;
        send(8'h81, 4'd1, 1'b1);
        tick();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        bus.in_shamt = 4'd2;
        bus.in_dir   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("t5_hold_valid", bus.out_valid, 1);
            check("t5_hold_data",  bus.out_data,  8'h02);
            check("t5_hold_ready", bus.in_ready,  0);
            tick();
        end
        check("t5_last_valid", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        tick();
        check("t5_idle_ready", bus.in_ready, 1);
        check("t5_idle_busy",  bus.busy,     0);
        check("t5_idle_data",  bus.out_data, 8'h02);
        tick();
        bus.in_valid = 1'b0;
        check("t5_acc_busy",  bus.busy,     1);
        check("t5_acc_shdat", bus.sh_data,  8'h55);
        check("t5_acc_shamt", bus.sh_shamt, 2);
        check("t5_acc_dir",   bus.sh_dir,   0);
        tick();
        check("t5_res_valid", bus.out_valid, 1);
        check("t5_res_data",  bus.out_data,  8'h15);
        tick();

        // 6: reset during the second SHIFT cycle of a 15-bit request
        send(8'hFF, 4'd15, 1'b1);
        tick();
        check("t6_pre_shamt", bus.sh_shamt, 7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_valid",    bus.out_valid, 0);
        check("t6_data",     bus.out_data,  0);
        check("t6_busy",     bus.busy,      0);
        check("t6_in_ready", bus.in_ready,  1);
        check("t6_shamt",    bus.sh_shamt,  0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t6_no_valid", bus.out_valid, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/seq_shift_ctrl.md
Name: seq_shift_ctrl

Overview:
- Upstream sequencer for the 8-bit combinational barrel shifter (3-bit shift amount, direction select, zero fill).
- Accepts shift requests with amounts 0..15 over a valid/ready handshake.
- Splits each request into passes of at most 7 bits through the external shifter, accumulating the result in a register.
- Presents the final result on a valid/ready output.

Parameters:
- DATA_W, 8, operand width; fixed at 8 to match the shifter datapath.
- AMT_W, 4, request shift-amount width; amounts 0..(2^AMT_W-1).
- MAX_STEP, 7, largest per-pass amount the shifter accepts (3-bit shamt).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  request accept; high only in IDLE.
- in_data  input  8  operand.
- in_shamt  input  4  total shift amount.
- in_dir  input  1  0 = logical right (toward bit 0), 1 = logical left; zero fill both ways.
- sh_data  output  8  operand to shifter; equals the accumulator register.
- sh_shamt  output  3  per-pass amount to shifter.
- sh_dir  output  1  direction to shifter; equals the latched direction.
- sh_result  input  8  combinational shifter result, captured on the clock edge.
- out_valid  output  1  result valid.
- out_ready  input  1  result accept.
- out_data  output  8  result; equals the accumulator register.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Registers: state, acc[7:0], rem[3:0], dir_r.
- Reset (rst=1 at an edge): state=IDLE, acc=0, rem=0, dir_r=0.
  - After reset: in_ready=1, out_valid=0, out_data=0, busy=0, sh_shamt=0, sh_dir=0, sh_data=0.
  - Reset overrides any in-flight request; the request is discarded and no output is produced.
- IDLE: in_ready=1, sh_shamt=0.
  - On in_valid: acc<=in_data, rem<=in_shamt, dir_r<=in_dir.
  - in_shamt==0: next state DONE; otherwise next state SHIFT.
- SHIFT: in_ready=0.
  - step = (rem>MAX_STEP) ? 7 : rem[2:0]; sh_shamt=step.
  - Each edge: acc<=sh_result, rem<=rem-step.
  - When rem-step==0, next state DONE; otherwise stay in SHIFT.
  - Pass count = ceil(amt/7): amt 1-7 is 1 pass, 8-14 is 2, 15 is 3.
- DONE: out_valid=1, in_ready=0, sh_shamt=0.
  - On out_ready: next state IDLE.
  - out_data is held stable while out_ready=0.
  - in_valid in DONE is ignored, including a cycle where out_ready=1; a new request is accepted only in IDLE, so back-to-back requests have a 1-cycle bubble.
- Latency, counted from the accept edge (cycle 0):
  - amt 0: out_valid from cycle 1.
  - amt 1-7: out_valid from cycle 2.
  - amt 8-14: out_valid from cycle 3.
  - amt 15: out_valid from cycle 4.
- Amounts >=8 naturally yield 0x00; no special-case logic.
- sh_* outputs are combinational from the registers only; there is no combinational path from in_* to sh_*.

Test Plan:
1. in_data=0xB5, shamt=3, dir=1, out_ready=1.
   - Required: one SHIFT cycle with sh_shamt=3, sh_dir=1.
   - Required: out_data=0xA8 with out_valid at cycle 2, then IDLE at cycle 3.
2. in_data=0xB5, shamt=3, dir=0.
   - Required: out_data=0x16 at cycle 2.
3. in_data=0xFF, shamt=8, dir=0.
   - Required: pass 1 sh_shamt=7 (acc=0x01), pass 2 sh_shamt=1 (acc=0x00).
   - Required: out_data=0x00 at cycle 3.
   - Repeat with shamt=15: passes 7,7,1 and out_valid at cycle 4.
4. in_data=0x3C, shamt=0.
   - Required: no SHIFT cycle, sh_shamt stays 0, out_data=0x3C with out_valid at cycle 1.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new data.
   - Required: out_valid=1 and out_data unchanged throughout, in_ready=0, new request not taken.
   - Required: request accepted only in the first IDLE cycle after out_ready=1.
6. Assert rst during the second SHIFT cycle of a shamt=15 request.
   - Required: next cycle IDLE, out_valid=0, out_data=0, busy=0, in_ready=1.
   - Required: no out_valid pulse for the aborted request.
